// File: rtl/proj_fm_read_sched.sv
// proj_fm_read_sched: read-side scheduler for the ping-pong genome FM buffer.
// After each buffer swap it walks the readable buffer window by window. Each
// window start address goes to one hashing lane chosen round-robin. The block
// drives the FM RAM read port and tags each returned window with its lane.
//
// Ports:
//   in_clk, in_rst       clock, asynchronous active-high reset
//   in_swap, in_rd_idx   buffer-ready pulse and index of the readable buffer
//   in_lane_ready        per-lane request for one window
//   in_clr_overrun       clears out_overrun (a new overrun takes priority)
//   out_ram_ren/raddr/rd_idx   combinational FM RAM read port
//   out_lane_valid, out_win_addr   registered delivery tag, 1 cycle after the read
//   out_busy, out_done, out_overrun   scan status
//   out_stall_cnt        only with PROJ_FM_SCHED_STATS_EN: saturating count of
//                        SCAN cycles with no lane ready
module proj_fm_read_sched #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned WINDOW    = 8,
    parameter int unsigned STRIDE    = 1
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_swap,
    input  logic                 in_rd_idx,
    input  logic [LANES-1:0]     in_lane_ready,
    input  logic                 in_clr_overrun,
    output logic                 out_ram_ren,
    output logic [ADDR_BITS-1:0] out_ram_raddr,
    output logic                 out_ram_rd_idx,
    output logic [LANES-1:0]     out_lane_valid,
    output logic [ADDR_BITS-1:0] out_win_addr,
    output logic                 out_busy,
    output logic                 out_done,
    output logic                 out_overrun
`ifdef PROJ_FM_SCHED_STATS_EN
    ,
    output logic [15:0]          out_stall_cnt
`endif
);

    localparam int unsigned PTR_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned BUF_BYTES = 1 << ADDR_BITS;
    localparam int unsigned LAST      = ((BUF_BYTES - WINDOW) / STRIDE) * STRIDE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] cur_addr_q;
    logic                 rd_idx_q;
    logic                 pend_q;
    logic                 pend_idx_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [LANES-1:0]     lane_valid_q;
    logic [ADDR_BITS-1:0] win_addr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 overrun_q;

    logic [LANES-1:0]     gnt_vec;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 gnt_found;
    logic                 grant;
    logic                 at_last;
    logic                 last_grant;
    logic                 swap_restart;

    // Round-robin search starting at rr_ptr_q (the lane after the last grant)
    always_comb begin
        gnt_vec   = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            automatic int unsigned j = (32'(rr_ptr_q) + i) % LANES;
            if (!gnt_found && in_lane_ready[j]) begin
                gnt_found  = 1'b1;
                gnt_vec[j] = 1'b1;
                gnt_idx    = PTR_W'(j);
            end
        end
    end

    assign grant        = (state_q == S_SCAN) && gnt_found;
    assign at_last      = (cur_addr_q == ADDR_BITS'(LAST));
    assign last_grant   = grant && at_last;
    // A swap mid-scan abandons the old buffer unless the final window goes out now
    assign swap_restart = (state_q == S_SCAN) && in_swap && !last_grant;

    // FSM state register
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_swap) state_d = S_SCAN;
            S_SCAN:  begin
                if (swap_restart)    state_d = S_SCAN;
                else if (last_grant) state_d = S_FLUSH;
            end
            S_FLUSH: state_d = (in_swap || pend_q) ? S_SCAN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: RAM read port, combinational so the RAM samples it next edge
    always_comb begin
        out_ram_ren    = 1'b0;
        out_ram_raddr  = '0;
        out_ram_rd_idx = 1'b0;
        if (grant) begin
            out_ram_ren    = 1'b1;
            out_ram_raddr  = cur_addr_q;
            out_ram_rd_idx = rd_idx_q;
        end
    end

    // Scan address, buffer index, pending swap and round-robin pointer
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cur_addr_q <= '0;
            rd_idx_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            if (grant) begin
                rr_ptr_q <= PTR_W'((32'(gnt_idx) + 32'd1) % LANES);
            end
            unique case (state_q)
                S_IDLE: begin
                    cur_addr_q <= '0;
                    if (in_swap) rd_idx_q <= in_rd_idx;
                end
                S_SCAN: begin
                    if (swap_restart) begin
                        cur_addr_q <= '0;
                        rd_idx_q   <= in_rd_idx;
                    end else if (grant) begin
                        cur_addr_q <= cur_addr_q + ADDR_BITS'(STRIDE);
                    end
                    // Swap coinciding with the last grant starts the next scan after FLUSH
                    if (in_swap && last_grant) begin
                        pend_q     <= 1'b1;
                        pend_idx_q <= in_rd_idx;
                    end
                end
                S_FLUSH: begin
                    cur_addr_q <= '0;
                    pend_q     <= 1'b0;
                    if (in_swap)     rd_idx_q <= in_rd_idx;
                    else if (pend_q) rd_idx_q <= pend_idx_q;
                end
                default: cur_addr_q <= '0;
            endcase
        end
    end

    // Delivery tag aligned with registered RAM read data, plus status flags
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            lane_valid_q <= '0;
            win_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            lane_valid_q <= grant ? gnt_vec : '0;
            if (grant) win_addr_q <= cur_addr_q;
            busy_q <= (state_d != S_IDLE);
            done_q <= (state_d == S_FLUSH);
            if (swap_restart)        overrun_q <= 1'b1;
            else if (in_clr_overrun) overrun_q <= 1'b0;
        end
    end

    assign out_lane_valid = lane_valid_q;
    assign out_win_addr   = win_addr_q;
    assign out_busy       = busy_q;
    assign out_done       = done_q;
    assign out_overrun    = overrun_q;

`ifdef PROJ_FM_SCHED_STATS_EN
    logic [15:0] stall_q;

    // Saturating count of SCAN cycles with no lane ready
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && in_swap) begin
            stall_q <= '0;
        end else if ((state_q == S_SCAN) && !(|in_lane_ready) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign out_stall_cnt = stall_q;
`endif

endmodule

// File: doc/proj_fm_read_sched.md
# proj_fm_read_sched

Read-side scheduler for the ping-pong genome FM buffer. After each buffer swap it walks the completed (read) buffer window by window. Each window start address goes to one of several MinHash hashing lanes through round-robin arbitration. It drives the FM RAM read port and tags each returned window with its destination lane. It sits between the FM RAM and the hash-lane array, and flags overrun when the writer swaps buffers before the scan has finished.

## Interface
Parameters:
- `LANES`, 4, number of hashing lanes requesting windows
- `ADDR_BITS`, 10, FM buffer address width; buffer size = 2^ADDR_BITS bytes
- `WINDOW`, 8, bytes per read window (RAM read width in bytes)
- `STRIDE`, 1, address increment between consecutive windows

Ports:
- `in_clk`  in  1  clock
- `in_rst`  in  1  reset, asynchronous, active-high
- `in_swap`  in  1  one-cycle pulse: a buffer has just been fully written and is now readable
- `in_rd_idx`  in  1  index of the newly readable buffer, sampled when `in_swap`=1
- `in_lane_ready`  in  LANES  lane i can accept one window this cycle
- `in_clr_overrun`  in  1  clears `out_overrun`
- `out_ram_ren`  out  1  read enable to FM RAM
- `out_ram_raddr`  out  ADDR_BITS  window start address
- `out_ram_rd_idx`  out  1  buffer index to read
- `out_lane_valid`  out  LANES  one-hot; the RAM read data this cycle belongs to lane i
- `out_win_addr`  out  ADDR_BITS  start address of the window delivered this cycle
- `out_busy`  out  1  scan in progress
- `out_done`  out  1  one-cycle pulse with the last window delivery of a buffer
- `out_overrun`  out  1  sticky: a swap arrived before the scan completed

## Operation
- `LAST` = largest multiple of `STRIDE` ≤ 2^ADDR_BITS − `WINDOW`. Windows are dispatched in increasing address order, 0 through `LAST`.
- FSM states: `IDLE`, `SCAN`, `FLUSH`.
  - `IDLE`: on `in_swap`, latch `in_rd_idx`, set cur_addr=0, go to `SCAN`.
  - `SCAN`: if any `in_lane_ready` bit is set, grant exactly one lane round-robin. The search starts at the lane after the last granted lane; the pointer resets to lane 0.
    - On a grant: `out_ram_ren`=1, `out_ram_raddr`=cur_addr, `out_ram_rd_idx`=latched index (combinational from state and ready).
    - cur_addr advances by `STRIDE`.
    - A grant at `LAST` goes to `FLUSH`.
    - With no lane ready: no read, cur_addr holds.
  - `FLUSH`: one cycle delivering the last window; `out_done`=1. Next state is `SCAN` (new index, addr 0) if `in_swap`, else `IDLE`.
- Delivery: a grant to lane i at cycle t gives `out_lane_valid[i]`=1 and `out_win_addr`=granted addr at t+1, aligned with the RAM's registered read data.
- Swap in `SCAN`:
  - If the same cycle grants `LAST`, there is no overrun; proceed to `FLUSH` and keep the new index pending to start the next scan after `FLUSH`.
  - Otherwise set `out_overrun`. Any grant that cycle still reads the old buffer. From t+1 the FSM scans the new index from address 0, and the remaining old windows are dropped.
- Swap in `FLUSH`: no overrun.
- `out_overrun`: set has priority over `in_clr_overrun` in the same cycle.
- `out_busy`=1 in `SCAN` and `FLUSH`.

## Timing
- Reset values: all outputs 0, FSM=`IDLE`, round-robin pointer=0, cur_addr=0.
- Reset asserted mid-scan aborts immediately; no further valid pulses.
- Read-to-delivery latency: 1 cycle.
- Throughput: 1 window per cycle while any lane is ready.
- First grant possible in the cycle after `in_swap`.
- A lane holding ready high may be granted on consecutive cycles only if no other lane is ready.
- `out_lane_valid` is registered.
- `out_ram_*` are combinational; the RAM samples them at the next edge.

## Configuration
- `PROJ_FM_SCHED_STATS_EN`
- Defined: adds output `out_stall_cnt` [15:0]. It counts cycles spent in `SCAN` with no lane ready and saturates at 0xFFFF. It clears on reset and on each `in_swap` accepted from `IDLE`.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
Scenarios 1–4 use `ADDR_BITS`=4, `WINDOW`=4, `STRIDE`=4, `LANES`=4, giving `LAST`=12.
1. Reset, then swap with `in_rd_idx`=1 and all lanes ready.
   - Reads at addrs 0, 4, 8, 12 on 4 consecutive cycles to lanes 0, 1, 2, 3.
   - Valid pulses follow 1 cycle later.
   - `out_done` is high with the addr-12 delivery, then `IDLE`; `out_busy` is low after.
2. Only lane 2 ready.
   - All 4 windows go to lane 2 on consecutive cycles.
   - Dropping ready for 3 cycles mid-scan stalls cur_addr; there are no `out_ram_ren` pulses during the stall.
3. Swap issued while cur_addr=8 with no grant that cycle.
   - `out_overrun`=1.
   - Next read is addr 0 with the new index.
   - `in_clr_overrun` the following cycle clears it.
4. Swap in the same cycle as the addr-12 grant.
   - No overrun.
   - `FLUSH`, then `SCAN` from addr 0 with the new index, with no idle cycle between.
5. `in_rst` asserted asynchronously mid-scan: all outputs 0 immediately; the next swap restarts cleanly at addr 0 with the pointer at lane 0.
6. With `PROJ_FM_SCHED_STATS_EN`: 5 no-ready cycles in `SCAN` give `out_stall_cnt`=5; a new swap from `IDLE` clears it to 0.
